// File: rtl/dw01_bindec_seq.sv
// dw01_bindec_seq -- registered binary-to-one-hot decoder with valid/ready
// handshakes and an optional "walk" mode that emits one beat per bit, from
// the requested bit down to bit 0.
//
// Optional feature macro: DW01_BINDEC_SWEEP_EN
//   defined   -> walk mode (sweep=1) available, SWEEP state and down-counter present
//   undefined -> sweep input ignored, every request is a single decode, busy=0
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request present            in_ready   request accepted this cycle
//   addr       bit number to decode       sweep      1 = walk mode, 0 = single decode
//   out_valid  output beat present        out_ready  downstream takes the beat
//   A          one-hot (or zero) word     err        beat is an out-of-range address
//   busy       high while walking (SWEEP state)
module dw01_bindec_seq #(
    parameter int A_width    = 32,
    parameter int ADDR_width = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_width-1:0] addr,
    input  logic                  sweep,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [A_width-1:0]    A,
    output logic                  err,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, HOLD, SWEEP} state_t;

    localparam logic [ADDR_width:0]  A_LIM = (ADDR_width+1)'(A_width);
    localparam logic [A_width-1:0]   ONE   = A_width'(1);

    state_t             state, state_n;
    logic [A_width-1:0] a_q, a_n;
    logic               err_q, err_n;
    logic               accept, consume;
    logic               is_null, in_range, do_sweep;

    assign out_valid = (state != IDLE);
    assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;
    assign A         = a_q;
    assign err       = err_q;

    assign is_null  = (addr == '1);
    assign in_range = ({1'b0, addr} < A_LIM);

`ifdef DW01_BINDEC_SWEEP_EN
    // cnt_q holds the bit number of the next beat to present while walking.
    logic [ADDR_width-1:0] cnt_q, cnt_n;

    assign do_sweep = sweep && in_range && (addr != '0);
    assign busy     = (state == SWEEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_n;
    end
`else
    logic unused_sweep;
    assign unused_sweep = sweep;
    assign do_sweep     = 1'b0;
    assign busy         = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            a_q   <= a_n;
            err_q <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        a_n     = a_q;
        err_n   = err_q;
`ifdef DW01_BINDEC_SWEEP_EN
        cnt_n   = cnt_q;
`endif
        case (state)
            IDLE, HOLD: begin
                if (accept) begin
                    // New request: null code and out-of-range both give a
                    // zero word; only out-of-range is flagged as an error.
                    state_n = HOLD;
                    err_n   = 1'b0;
                    if (is_null) begin
                        a_n = '0;
                    end else if (!in_range) begin
                        a_n   = '0;
                        err_n = 1'b1;
                    end else begin
                        a_n = ONE << addr;
                    end
                    if (do_sweep) begin
                        state_n = SWEEP;
`ifdef DW01_BINDEC_SWEEP_EN
                        cnt_n   = addr - ADDR_width'(1);
`endif
                    end
                end else if ((state == HOLD) && consume) begin
                    state_n = IDLE;
                    a_n     = '0;
                    err_n   = 1'b0;
                end
            end
            SWEEP: begin
`ifdef DW01_BINDEC_SWEEP_EN
                // The bit-0 beat is presented from HOLD, so busy drops as the
                // final beat goes out and the counter never goes below zero.
                if (consume) begin
                    a_n = ONE << cnt_q;
                    if (cnt_q == '0) state_n = HOLD;
                    else             cnt_n   = cnt_q - ADDR_width'(1);
                end
`else
                state_n = IDLE;
`endif
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dw01_bindec_seq.sv
module tb_dw01_bindec_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  addr = '0;
    logic        sweep = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] A;
    logic        err;
    logic        busy;

    int checks = 0;
    int failures = 0;

    dw01_bindec_seq #(.A_width(32), .ADDR_width(6)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .addr(addr), .sweep(sweep), .out_valid(out_valid), .out_ready(out_ready),
        .A(A), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [5:0]  ad;
        logic        sw;
        logic        ordy;
        logic        e_ov;
        logic [31:0] e_a;
        logic        e_err;
        logic        e_rdy;
        logic        e_busy;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [5:0] ad, input logic sw, input logic ordy,
                       input logic e_ov, input logic [31:0] e_a, input logic e_err,
                       input logic e_rdy, input logic e_busy, input string name);
        vec_t v;
        v.iv = iv; v.ad = ad; v.sw = sw; v.ordy = ordy;
        v.e_ov = e_ov; v.e_a = e_a; v.e_err = e_err; v.e_rdy = e_rdy; v.e_busy = e_busy;
        v.name = name;
        vecs.push_back(v);
    endtask

    // Drive inputs, clock once, then compare outputs 1 time unit after the edge.
    task automatic step(input logic iv, input logic [5:0] ad, input logic sw, input logic ordy);
        in_valid = iv; addr = ad; sweep = sw; out_ready = ordy;
        @(posedge clk); #1;
    endtask

    task automatic chk_all(input string name, input logic e_ov, input logic [31:0] e_a,
                           input logic e_err, input logic e_rdy, input logic e_busy);
        chk({name, ".out_valid"}, 32'(out_valid), 32'(e_ov));
        chk({name, ".A"},         A,              e_a);
        chk({name, ".err"},       32'(err),       32'(e_err));
        chk({name, ".in_ready"},  32'(in_ready),  32'(e_rdy));
        chk({name, ".busy"},      32'(busy),      32'(e_busy));
    endtask

    initial begin
        // ---------------- vector table ----------------
        add(1, 6'd5,  0, 1,  1, 32'h0000_0020, 0, 1, 0, "dec5");
        add(0, 6'd0,  0, 1,  0, 32'h0,         0, 1, 0, "dec5_drain");
        add(1, 6'h3F, 0, 1,  1, 32'h0,         0, 1, 0, "null");
        add(1, 6'd40, 0, 1,  1, 32'h0,         1, 1, 0, "oor40_b2b");
        add(0, 6'd0,  0, 1,  0, 32'h0,         0, 1, 0, "oor_drain");
        add(1, 6'd31, 0, 0,  1, 32'h8000_0000, 0, 0, 0, "dec31_stall0");
        add(0, 6'd0,  0, 0,  1, 32'h8000_0000, 0, 0, 0, "stall1");
        add(0, 6'd0,  0, 0,  1, 32'h8000_0000, 0, 0, 0, "stall2");
        add(1, 6'd7,  0, 0,  1, 32'h8000_0000, 0, 0, 0, "stall3_ignored");
        add(1, 6'd0,  0, 1,  1, 32'h0000_0001, 0, 1, 0, "dec0_nobubble");
        add(0, 6'd0,  0, 1,  0, 32'h0,         0, 1, 0, "dec0_drain");
        add(1, 6'd32, 0, 1,  1, 32'h0,         1, 1, 0, "oor32_edge");
        add(1, 6'd30, 0, 1,  1, 32'h4000_0000, 0, 1, 0, "dec30");
        add(1, 6'd50, 1, 1,  1, 32'h0,         1, 1, 0, "oor50_sweep");
        add(1, 6'h3F, 1, 1,  1, 32'h0,         0, 1, 0, "null_sweep");
        add(0, 6'd0,  0, 1,  0, 32'h0,         0, 1, 0, "idle");
`ifdef DW01_BINDEC_SWEEP_EN
        add(1, 6'd3,  1, 1,  1, 32'h8,         0, 0, 1, "sw3_b8");
        add(0, 6'd0,  0, 1,  1, 32'h4,         0, 0, 1, "sw3_b4");
        add(0, 6'd0,  0, 1,  1, 32'h2,         0, 0, 1, "sw3_b2");
        add(0, 6'd0,  0, 1,  1, 32'h1,         0, 1, 0, "sw3_b1");
        add(0, 6'd0,  0, 1,  0, 32'h0,         0, 1, 0, "sw3_done");
        add(1, 6'd2,  1, 0,  1, 32'h4,         0, 0, 1, "sw2_stall");
        add(0, 6'd0,  0, 0,  1, 32'h4,         0, 0, 1, "sw2_stall_hold");
        add(0, 6'd0,  0, 1,  1, 32'h2,         0, 0, 1, "sw2_b2");
        add(0, 6'd0,  0, 1,  1, 32'h1,         0, 1, 0, "sw2_b1");
        add(1, 6'd0,  1, 1,  1, 32'h1,         0, 1, 0, "sw0_single");
        add(0, 6'd0,  0, 1,  0, 32'h0,         0, 1, 0, "sw0_done");
`else
        add(1, 6'd3,  1, 1,  1, 32'h8,         0, 1, 0, "nosweep3");
        add(0, 6'd0,  0, 1,  0, 32'h0,         0, 1, 0, "nosweep3_done");
`endif

        // ---------------- reset state ----------------
        #2;
        chk_all("reset", 0, 32'h0, 0, 1, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_all("post_reset", 0, 32'h0, 0, 1, 0);

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            step(vecs[i].iv, vecs[i].ad, vecs[i].sw, vecs[i].ordy);
            chk_all(vecs[i].name, vecs[i].e_ov, vecs[i].e_a, vecs[i].e_err,
                    vecs[i].e_rdy, vecs[i].e_busy);
        end

        // ---------------- reset in the middle of a transfer ----------------
`ifdef DW01_BINDEC_SWEEP_EN
        step(1, 6'd10, 1, 1);
        chk("rst_sw.b1", A, 32'h400);
        step(0, 6'd0, 0, 1);
        chk("rst_sw.b2", A, 32'h200);
        step(0, 6'd0, 0, 1);
        chk("rst_sw.b3", A, 32'h100);
        chk("rst_sw.busy_before", 32'(busy), 32'h1);
`else
        step(1, 6'd10, 0, 0);
        chk("rst_hold.beat", A, 32'h400);
`endif
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 32'h0, 0, 1, 0);
        step(0, 6'd0, 0, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_all("rst_release", 0, 32'h0, 0, 1, 0);
        for (int k = 0; k < 4; k++) begin
            step(0, 6'd0, 0, 1);
            chk("no_stale_beat", 32'(out_valid), 32'h0);
        end
        step(1, 6'd1, 0, 1);
        chk_all("after_rst_dec1", 1, 32'h2, 0, 1, 0);
        step(0, 6'd0, 0, 1);
        chk("after_rst_drain", 32'(out_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no end expected end");
        $fatal(1);
    end

endmodule
